// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine and the register file it reads.
// Holds the dump FSM state type and the register-file geometry.
package regfile_dump_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StDone
    } state_e;

endpackage

// File: rtl/regfile_dump.sv
// Sequential register-file dump: walks a programmed index range through one read port and
// streams (index, data) pairs over a valid/ready interface, with a done pulse at the end.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int unsigned NREG = regfile_dump_pkg::NREG,
    parameter int unsigned AW   = regfile_dump_pkg::AW,
    parameter int unsigned DW   = regfile_dump_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] rd_sel,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_index,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    state_e        state_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] last_q;
    logic [AW-1:0] rd_sel_q;
    logic          out_valid_q;
    logic [AW-1:0] out_index_q;
    logic [DW-1:0] out_data_q;
    logic          busy_q;
    logic          done_q;

    logic          handshake;
    logic          at_last;
    logic [AW-1:0] idx_d;

    // AW bits exactly span NREG, so the increment wraps modulo NREG by itself.
    always_comb begin
        handshake = out_valid_q & out_ready;
        at_last   = (idx_q == last_q);
        idx_d     = idx_q + AW'(1);
    end

    // The start index lives on in idx_q, so only the end of the range is latched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            last_q      <= '0;
            rd_sel_q    <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q    <= first;
                        last_q   <= last;
                        rd_sel_q <= first;
                        busy_q   <= 1'b1;
                        state_q  <= StRead;
                    end
                end
                StRead: begin
                    out_data_q  <= rd_data;
                    out_index_q <= idx_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StSend;
                end
                StSend: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (at_last) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q    <= idx_d;
                            rd_sel_q <= idx_d;
                            state_q  <= StRead;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rd_sel    = rd_sel_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a register-file model feeds the read port, a scoreboard
// queue holds the expected stream, and a cycle-stepped sink applies backpressure.
module tb_regfile_dump;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic [AW-1:0] rd_sel;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_index;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [32];
    logic [AW+DW-1:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_sel];

    regfile_dump dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first     (first),
        .last      (last),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one dump of f..l. stall: ready held low for that many valid cycles per entry.
    // inject_at: cycle in which a second start (first=5) is pulsed. reset_at: index whose
    // SEND cycle gets a reset instead of a handshake.
    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int stall,
                            input int inject_at, input int reset_at);
        logic [AW-1:0] span;
        logic [AW-1:0] k;
        logic [AW+DW-1:0] e;
        logic [AW-1:0] held_i;
        logic [DW-1:0] held_d;
        int n;
        int c;
        int sc;
        int first_valid;
        int done_cycle;
        bit stalled;

        span = l - f;
        n = int'(span) + 1;
        for (int i = 0; i < n; i++) begin
            k = f + AW'(i);
            exp_q.push_back({k, (k == '0) ? 32'h0 : (32'h1000 + 32'(k))});
        end

        @(negedge clk);
        start     = 1'b1;
        first     = f;
        last      = l;
        out_ready = (stall == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        c = 1;
        sc = 0;
        stalled = 1'b0;
        first_valid = -1;
        done_cycle = -1;
        check("busy_cycle1", busy, 1);

        while (c < 2000) begin
            check("valid_done_excl", out_valid & done, 0);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_index", out_index, held_i);
                check("stall_data", out_data, held_d);
            end
            if (done) begin
                done_cycle = c;
                break;
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = c;
                if (reset_at >= 0 && int'(out_index) == reset_at) begin
                    out_ready = 1'b0;
                    reset     = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    check("rst_rd_sel", rd_sel, 0);
                    check("rst_out_valid", out_valid, 0);
                    check("rst_out_index", out_index, 0);
                    check("rst_out_data", out_data, 0);
                    check("rst_busy", busy, 0);
                    check("rst_done", done, 0);
                    for (int j = 0; j < 4; j++) begin
                        @(posedge clk);
                        #1;
                        check("rst_no_done", done, 0);
                        check("rst_no_valid", out_valid, 0);
                    end
                    exp_q.delete();
                    return;
                end
                if (sc < stall) begin
                    out_ready = 1'b0;
                    sc++;
                    stalled = 1'b1;
                    held_i  = out_index;
                    held_d  = out_data;
                end else begin
                    out_ready = 1'b1;
                    sc = 0;
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("extra_entry", out_index, 32'hdead);
                    end else begin
                        e = exp_q.pop_front();
                        check("entry_index", out_index, e[AW+DW-1:DW]);
                        check("entry_data", out_data, e[DW-1:0]);
                    end
                end
            end else begin
                out_ready = (stall == 0);
                stalled = 1'b0;
            end
            if (c == inject_at) begin
                start = 1'b1;
                first = 5'd5;
                last  = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;

        if (done_cycle < 0) check("done_timeout", 0, 1);
        check("done_cycle", done_cycle, n * (stall + 2) + 1);
        check("first_valid_cycle", first_valid, 2);
        check("busy_in_done", busy, 1);
        check("entries_left", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("idle_no_valid", out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
        regs[0]   = 32'h0;
        reset     = 1'b1;
        start     = 1'b0;
        first     = '0;
        last      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_sel", rd_sel, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_index", out_index, 0);
        check("reset_out_data", out_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;

        run_dump(5'd0, 5'd31, 0, -1, -1);
        run_dump(5'd30, 5'd1, 0, -1, -1);
        run_dump(5'd7, 5'd7, 0, -1, -1);
        run_dump(5'd3, 5'd8, 3, -1, -1);
        run_dump(5'd0, 5'd3, 0, 3, -1);
        run_dump(5'd0, 5'd31, 0, -1, 10);
        run_dump(5'd2, 5'd12, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
